// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg: state encoding and BCD constants shared by the count_ctrl slice
package count_ctrl_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
   localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
endpackage

// File: rtl/count_ctrl_tick_gen.sv
// tick_gen: prescaler that flags the last CLK cycle of each TICK_DIV-cycle count period
module tick_gen #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic CLK,
   input  logic RST,
   input  logic run,
   input  logic clr,
   output logic step
);
   localparam int W = $clog2(TICK_DIV);
   localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
   logic [W-1:0] pre_q, pre_d;
   always_comb begin
      step  = run && pre_q == LAST;
      pre_d = (clr || step) ? '0 : run ? pre_q + W'(1) : pre_q;
   end
   always_ff @(posedge CLK) begin
      if (RST) pre_q <= '0;
      else     pre_q <= pre_d;
   end
endmodule

// File: rtl/count_ctrl.sv
// count_ctrl: run/pause/clear sequencer stepping a binary count and a matching BCD digit pair.
// Optional COUNT_CTRL_UPDOWN_EN adds a DIR input for down counting.
module count_ctrl
   import count_ctrl_pkg::*;
#(
   parameter int TICK_DIV  = 50_000_000,
   parameter int MAX_COUNT = 99,
   parameter bit WRAP      = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       EN,
   input  logic       START,
   input  logic       STOP,
   input  logic       CLR,
`ifdef COUNT_CTRL_UPDOWN_EN
   input  logic       DIR,
`endif
   output logic [7:0] OUT,
   output logic [3:0] DIG0,
   output logic [3:0] DIG1,
   output logic       TICK,
   output logic       WRAPP,
   output logic       DONE,
   output logic [1:0] STATE
);
   localparam logic [7:0] MAX_Q  = 8'(MAX_COUNT);
   localparam logic [3:0] MAX_D1 = 4'(MAX_COUNT / 10);
   localparam logic [3:0] MAX_D0 = 4'(MAX_COUNT % 10);
   state_t     state_q, state_d;
   logic [7:0] out_q, out_d;
   logic [3:0] dig0_q, dig0_d, dig1_q, dig1_d;
   logic       tick_q, tick_d, wrapp_q, wrapp_d;
   logic       down, step, go, take, term;
`ifdef COUNT_CTRL_UPDOWN_EN
   assign down = DIR;
`else
   assign down = 1'b0;
`endif
   assign go = START & ~STOP & ~CLR;
   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .CLK (CLK),
      .RST (RST),
      .run (state_q == RUN && EN),
      .clr (CLR),
      .step(step)
   );
   // A step coinciding with STOP or CLR is dropped; the command wins.
   always_comb begin
      term    = down ? out_q == '0 : out_q == MAX_Q;
      take    = state_q == RUN && step && !STOP && !CLR;
      state_d = state_q;
      if (CLR) state_d = IDLE;
      else if ((state_q == IDLE || state_q == PAUSE) && go) state_d = RUN;
      else if (state_q == RUN && STOP) state_d = PAUSE;
      else if (take && term && !WRAP) state_d = count_ctrl_pkg::DONE;
   end
   always_comb begin
      out_d   = out_q;
      dig0_d  = dig0_q;
      dig1_d  = dig1_q;
      tick_d  = take && (WRAP || !term);
      wrapp_d = take && WRAP && term;
      if (CLR) {out_d, dig1_d, dig0_d} = '0;
      else if (state_q == IDLE && go && down) {out_d, dig1_d, dig0_d} = {MAX_Q, MAX_D1, MAX_D0};
      else if (take && term) begin
         if (WRAP) {out_d, dig1_d, dig0_d} = down ? {MAX_Q, MAX_D1, MAX_D0} : '0;
      end else if (take && down) begin
         out_d  = out_q - 8'd1;
         dig0_d = dig0_q == '0 ? BCD_MAX_DIGIT : dig0_q - 4'd1;
         dig1_d = dig0_q == '0 ? dig1_q - 4'd1 : dig1_q;
      end else if (take) begin
         out_d  = out_q + 8'd1;
         dig0_d = dig0_q == BCD_MAX_DIGIT ? '0 : dig0_q + 4'd1;
         dig1_d = dig0_q == BCD_MAX_DIGIT ? dig1_q + 4'd1 : dig1_q;
      end
   end
   always_ff @(posedge CLK) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         out_q   <= '0;
         dig0_q  <= '0;
         dig1_q  <= '0;
         tick_q  <= 1'b0;
         wrapp_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         dig0_q  <= dig0_d;
         dig1_q  <= dig1_d;
         tick_q  <= tick_d;
         wrapp_q <= wrapp_d;
      end
   end
   always_comb begin
      OUT   = out_q;
      DIG0  = dig0_q;
      DIG1  = dig1_q;
      TICK  = tick_q;
      WRAPP = wrapp_q;
      DONE  = state_q == count_ctrl_pkg::DONE;
      STATE = state_q;
   end
endmodule
